// File: rtl/gauss_frame_writer.sv
// Frame writer: places the Gaussian core's interior results into a full frame RAM,
// zero-fills the one-pixel border, and pulses frame_done_o after the last write.
module gauss_frame_writer #(
   parameter int unsigned IMG_W = 320,
   parameter int unsigned IMG_H = 240,
   parameter int unsigned DW    = 8,
   parameter int unsigned AW    = 17
) (
   input  logic          clk_i,
   input  logic          rst_i,
   input  logic          frame_start_i,
   input  logic          res_valid_i,
   input  logic [DW-1:0] res_data_i,
   output logic          res_ready_o,
   output logic          mem_we_o,
   output logic [AW-1:0] mem_addr_o,
   output logic [DW-1:0] mem_data_o,
   output logic          busy_o,
   output logic          frame_done_o,
   output logic          err_o
);

   localparam int unsigned CW = (IMG_W > 2) ? $clog2(IMG_W) : 1;
   localparam int unsigned RW = (IMG_H > 2) ? $clog2(IMG_H) : 1;

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_STREAM = 2'd1,
      S_DONE   = 2'd2
   } state_t;

   state_t        state;
   logic [CW-1:0] col;
   logic [RW-1:0] row;
   logic [AW-1:0] addr;

   logic last_col;
   logic last_row;
   logic border;
   logic step;

   // Position decode from the raster counters; border pixels never wait for the source.
   assign last_col    = (col == CW'(IMG_W - 1));
   assign last_row    = (row == RW'(IMG_H - 1));
   assign border      = (row == '0) || last_row || (col == '0) || last_col;
   assign res_ready_o = (state == S_STREAM) && !border;
   assign step        = (state == S_STREAM) && (border || res_valid_i);
   assign busy_o      = (state == S_STREAM);

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state        <= S_IDLE;
         col          <= '0;
         row          <= '0;
         addr         <= '0;
         mem_we_o     <= 1'b0;
         mem_addr_o   <= '0;
         mem_data_o   <= '0;
         frame_done_o <= 1'b0;
         err_o        <= 1'b0;
      end else begin
         mem_we_o     <= step;
         frame_done_o <= 1'b0;
         if (step) begin
            mem_addr_o <= addr;
            mem_data_o <= border ? '0 : res_data_i;
         end
         case (state)
            S_IDLE: begin
               if (frame_start_i) begin
                  state <= S_STREAM;
                  col   <= '0;
                  row   <= '0;
                  addr  <= '0;
                  err_o <= 1'b0;
               end else if (res_valid_i) begin
                  err_o <= 1'b1;
               end
            end
            S_STREAM: begin
               // Running address tracks row*IMG_W+col without a multiplier.
               if (step) begin
                  addr <= addr + AW'(1);
                  if (last_col) begin
                     col <= '0;
                     if (last_row) begin
                        state        <= S_DONE;
                        frame_done_o <= 1'b1;
                        row          <= '0;
                        addr         <= '0;
                     end else begin
                        row <= row + RW'(1);
                     end
                  end else begin
                     col <= col + CW'(1);
                  end
               end
            end
            S_DONE: begin
               state <= S_IDLE;
               if (res_valid_i) err_o <= 1'b1;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_gauss_frame_writer.sv
// Bench for gauss_frame_writer: 5x4 instance checked every cycle against a raster-index
// model, plus a default-size 320x240 instance run once at full rate.
module tb_gauss_frame_writer;

   localparam int unsigned W   = 5;
   localparam int unsigned H   = 4;
   localparam int unsigned WH  = W * H;
   localparam int unsigned DW  = 8;
   localparam int unsigned AW  = 5;
   localparam int unsigned BWH = 320 * 240;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   logic          start, valid;
   logic [DW-1:0] data;
   logic          ready, we, busy, done, err;
   logic [AW-1:0] addr;
   logic [DW-1:0] mdata;

   logic          b_start, b_valid;
   logic [7:0]    b_data;
   logic          b_ready, b_we, b_busy, b_done, b_err;
   logic [16:0]   b_addr;
   logic [7:0]    b_mdata;

   gauss_frame_writer #(.IMG_W(W), .IMG_H(H), .DW(DW), .AW(AW)) dut (
      .clk_i(clk), .rst_i(rst), .frame_start_i(start), .res_valid_i(valid),
      .res_data_i(data), .res_ready_o(ready), .mem_we_o(we), .mem_addr_o(addr),
      .mem_data_o(mdata), .busy_o(busy), .frame_done_o(done), .err_o(err));

   gauss_frame_writer dut_big (
      .clk_i(clk), .rst_i(rst), .frame_start_i(b_start), .res_valid_i(b_valid),
      .res_data_i(b_data), .res_ready_o(b_ready), .mem_we_o(b_we), .mem_addr_o(b_addr),
      .mem_data_o(b_mdata), .busy_o(b_busy), .frame_done_o(b_done), .err_o(b_err));

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   function automatic bit is_border(input int p);
      return (p / W == 0) || (p / W == H - 1) || (p % W == 0) || (p % W == W - 1);
   endfunction

   // Model: the frame is a list of raster indices; only interior ones consume source data.
   bit m_active  = 1'b0;
   bit m_donecyc = 1'b0;
   bit m_err     = 1'b0;
   int m_pos     = 0;
   bit e_we      = 1'b0;
   bit e_done    = 1'b0;
   int e_addr    = 0;
   int e_data    = 0;

   initial forever begin
      @(posedge clk or negedge rst);
      if (!rst) begin
         m_active = 0; m_donecyc = 0; m_err = 0; m_pos = 0;
         e_we = 0; e_done = 0; e_addr = 0; e_data = 0;
      end else begin
         e_we = 0;
         e_done = 0;
         if (m_active) begin
            if (is_border(m_pos) || valid) begin
               e_we   = 1;
               e_addr = m_pos;
               e_data = is_border(m_pos) ? 0 : int'(data);
               if (m_pos == WH - 1) begin
                  m_active  = 0;
                  m_donecyc = 1;
                  e_done    = 1;
               end else begin
                  m_pos++;
               end
            end
         end else if (m_donecyc) begin
            m_donecyc = 0;
            if (valid) m_err = 1;
         end else if (start) begin
            m_active = 1;
            m_pos    = 0;
            m_err    = 0;
         end else if (valid) begin
            m_err = 1;
         end
      end
   end

   int         wr_cnt = 0, rdy_cnt = 0, done_cnt = 0;
   logic [7:0] mem [32];

   initial forever begin
      @(negedge clk);
      chk("ready", 32'(ready), 32'(m_active && !is_border(m_pos)));
      chk("we", 32'(we), 32'(e_we));
      if (e_we) begin
         chk("addr", 32'(addr), 32'(e_addr));
         chk("wdata", 32'(mdata), 32'(e_data));
      end
      chk("busy", 32'(busy), 32'(m_active));
      chk("done", 32'(done), 32'(e_done));
      chk("err", 32'(err), 32'(m_err));
      if (we) begin
         wr_cnt++;
         mem[addr] = mdata;
      end
      if (ready) rdy_cnt++;
      if (done) done_cnt++;
   end

   task automatic clr();
      wr_cnt = 0; rdy_cnt = 0; done_cnt = 0;
      for (int i = 0; i < 32; i++) mem[i] = 8'hEE;
   endtask

   // Runs one small frame; gap_pct>0 gives random valid gaps and random data.
   task automatic frame(input int base, input int gap_pct, input int gap_after,
                        input int gap_len, input bit poke, output int cycles);
      int k = 0;
      int gap = 0;
      bit acc;
      @(negedge clk);
      start = 1; valid = 0;
      @(negedge clk);
      start = 0;
      cycles = 1;
      while (done !== 1'b1 && cycles < 500) begin
         if (gap > 0) begin
            valid = 0;
            gap--;
         end else begin
            valid = (gap_pct == 0) ? 1'b1 : (int'($urandom_range(99)) >= gap_pct);
         end
         data  = (gap_pct == 0) ? 8'(base + k) : 8'($urandom);
         start = poke && (cycles == 5);
         acc   = valid && ready;
         @(negedge clk);
         cycles++;
         if (acc) begin
            k++;
            if (k == gap_after) gap = gap_len;
         end
      end
      valid = 0;
      start = 0;
      chk("frame_end", 32'(done), 32'd1);
      @(negedge clk);
      #1;
   endtask

   task automatic img(input int base);
      for (int a = 0; a < int'(WH); a++) begin
         int r = a / W;
         int c = a % W;
         int exp = is_border(a) ? 0 : base + (r - 1) * (W - 2) + (c - 1);
         chk($sformatf("img[%0d]", a), 32'(mem[a]), 32'(exp));
      end
   endtask

   logic [7:0] bmem [BWH];
   int b_wr = 0, b_first = -1, b_last = -1, b_nzk = 0, b_bad = 0;

   initial forever begin
      @(negedge clk);
      if (b_we) begin
         b_wr++;
         bmem[b_addr] = b_mdata;
         if (b_mdata != 0) begin
            if (b_first < 0) b_first = int'(b_addr);
            b_last = int'(b_addr);
            if (b_mdata != 8'((b_nzk % 255) + 1)) b_bad++;
            b_nzk++;
         end
      end
   end

   initial begin
      int cyc, n, bk;
      bit bacc;
      start = 0; valid = 0; data = 0;
      b_start = 0; b_valid = 0; b_data = 0;
      #1;
      chk("rst_we", 32'(we), 0);      chk("rst_addr", 32'(addr), 0);
      chk("rst_wdata", 32'(mdata), 0); chk("rst_ready", 32'(ready), 0);
      chk("rst_busy", 32'(busy), 0);  chk("rst_done", 32'(done), 0);
      chk("rst_err", 32'(err), 0);    chk("rst_big_busy", 32'(b_busy), 0);
      chk("rst_big_err", 32'(b_err), 0);
      #20;
      @(negedge clk) rst = 1;
      repeat (2) @(negedge clk);

      // full-rate frame, data 10..15
      clr();
      frame(10, 0, 0, 0, 0, cyc);
      chk("t1_cycles", 32'(cyc), 32'(WH + 1));
      chk("t1_writes", 32'(wr_cnt), 20);
      chk("t1_ready_cycles", 32'(rdy_cnt), 6);
      chk("t1_done_cnt", 32'(done_cnt), 1);
      chk("t1_mem6", 32'(mem[6]), 10);
      chk("t1_mem13", 32'(mem[13]), 15);
      img(10);

      // 3-cycle gap before second result
      clr();
      frame(10, 0, 1, 3, 0, cyc);
      chk("t2_cycles", 32'(cyc), 32'(WH + 4));
      chk("t2_writes", 32'(wr_cnt), 20);
      img(10);

      // valid while idle sets err, no write; next start clears it
      clr();
      @(negedge clk); valid = 1; data = 8'hAA;
      @(negedge clk); valid = 0;
      #1;
      chk("t3_err_set", 32'(err), 1);
      chk("t3_no_write", 32'(wr_cnt), 0);
      frame(40, 0, 0, 0, 0, cyc);
      chk("t3_err_clr", 32'(err), 0);
      img(40);

      // start pulse while busy is ignored
      clr();
      frame(20, 0, 0, 0, 1, cyc);
      chk("t4_writes", 32'(wr_cnt), 20);
      chk("t4_done_cnt", 32'(done_cnt), 1);
      chk("t4_cycles", 32'(cyc), 32'(WH + 1));

      // reset after 8 writes
      clr();
      @(negedge clk) start = 1;
      @(negedge clk) start = 0; valid = 1; data = 8'd50;
      n = 0;
      while (wr_cnt < 8 && n < 100) begin
         @(negedge clk); #1; n++;
      end
      chk("t5_reach8", 32'(wr_cnt), 8);
      #1 rst = 0;
      #1;
      chk("t5_we", 32'(we), 0);      chk("t5_addr", 32'(addr), 0);
      chk("t5_wdata", 32'(mdata), 0); chk("t5_ready", 32'(ready), 0);
      chk("t5_busy", 32'(busy), 0);  chk("t5_done", 32'(done), 0);
      chk("t5_err", 32'(err), 0);
      valid = 0;
      repeat (3) @(negedge clk);
      #1;
      chk("t5_no_more_writes", 32'(wr_cnt), 8);
      chk("t5_no_done", 32'(done_cnt), 0);
      @(negedge clk) rst = 1;
      clr();
      frame(30, 0, 0, 0, 0, cyc);
      chk("t5_writes", 32'(wr_cnt), 20);
      img(30);

      // randomized gaps, data and idle-time valids
      for (int f = 0; f < 6; f++) begin
         clr();
         @(negedge clk); valid = 1'($urandom); data = 8'($urandom);
         @(negedge clk); valid = 0;
         frame(0, 40, 0, 0, f == 2, cyc);
         chk("rnd_writes", 32'(wr_cnt), 20);
         chk("rnd_done_cnt", 32'(done_cnt), 1);
      end

      // default 320x240 at full rate
      for (int i = 0; i < int'(BWH); i++) bmem[i] = 8'hFF;
      @(negedge clk) b_start = 1;
      @(negedge clk) b_start = 0; b_valid = 1;
      cyc = 1; bk = 0;
      while (b_done !== 1'b1 && cyc < 80000) begin
         b_data = 8'((bk % 255) + 1);
         bacc   = b_ready;
         @(negedge clk);
         cyc++;
         if (bacc) bk++;
      end
      b_valid = 0;
      chk("big_done", 32'(b_done), 1);
      @(negedge clk); #1;
      chk("big_cycles", 32'(cyc), 76801);
      chk("big_writes", 32'(b_wr), 76800);
      chk("big_accepts", 32'(bk), 75684);
      chk("big_nz_writes", 32'(b_nzk), 75684);
      chk("big_first", 32'(b_first), 321);
      chk("big_last", 32'(b_last), 76478);
      chk("big_data_order", 32'(b_bad), 0);
      chk("big_b0", 32'(bmem[0]), 0);
      chk("big_b319", 32'(bmem[319]), 0);
      chk("big_b320", 32'(bmem[320]), 0);
      chk("big_b76799", 32'(bmem[76799]), 0);
      chk("big_err", 32'(b_err), 0);
      chk("big_busy", 32'(b_busy), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
